// File: rtl/primitive_fetcher_pkg.sv
// Shared types for the primitive fetcher: vertex/triangle record layout and FSM states.
package Types;

   // Vertex packs as one memory word: {y[31:16], x[15:0]}.
   typedef struct packed {
      logic signed [15:0] y;
      logic signed [15:0] x;
   } Vertex;

   typedef struct packed {
      logic [2:0] colour;
      Vertex      v2;
      Vertex      v1;
      Vertex      v0;
   } TriangleData;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      COMMIT,
      DONE
   } FetcherState;

   localparam int unsigned WORDS_PER_TRIANGLE = 4;

endpackage

// File: rtl/primitive_fetcher_area.sv
// Signed doubled triangle area; non-positive means back-facing or degenerate.
// Only instantiated when ILLUSION_BACKFACE_CULL_EN is defined.
module TriangleArea
   import Types::*;
(
   input  Vertex              aV0,
   input  Vertex              aV1,
   input  Vertex              aV2,
   output logic signed [34:0] anOutArea
);

   logic signed [16:0] dx1, dy1, dx2, dy2;
   logic signed [33:0] p0, p1;

   always_comb begin
      dx1 = {aV1.x[15], aV1.x} - {aV0.x[15], aV0.x};
      dy1 = {aV1.y[15], aV1.y} - {aV0.y[15], aV0.y};
      dx2 = {aV2.x[15], aV2.x} - {aV0.x[15], aV0.x};
      dy2 = {aV2.y[15], aV2.y} - {aV0.y[15], aV0.y};
      p0  = 34'(dx1) * 34'(dy2);
      p1  = 34'(dx2) * 34'(dy1);
      anOutArea = 35'(p0) - 35'(p1);
   end

endmodule

// File: rtl/primitive_fetcher.sv
// Fetches a list of 4-word triangle records from memory into a slotted primitive cache.
// Optional back-face culling is enabled by defining ILLUSION_BACKFACE_CULL_EN.
module primitive_fetcher
   import Types::*;
#(
   parameter int DEPTH       = 32,
   parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
   input  logic                   aClock,
   input  logic                   aReset,
   input  logic                   aStart,
   input  logic [31:0]            aBaseAddr,
   input  logic [15:0]            aTriangleCount,
   output logic [31:0]            anOutMemoryAddr,
   input  logic [31:0]            aMemoryData,
   output logic                   anOutMemoryEnable,
   input  logic                   aMemoryValid,
   output logic [INDEX_WIDTH-1:0] anOutPrimitiveWriteAddress,
   output TriangleData            anOutPrimitiveWriteData,
   output logic                   anOutPrimitiveWriteEnable,
   input  logic                   aPrimitiveRelease,
   output logic [INDEX_WIDTH:0]   anOutOccupancy,
   output logic                   anOutBusy,
`ifdef ILLUSION_BACKFACE_CULL_EN
   output logic [15:0]            anOutCulledCount,
`endif
   output logic                   anOutDone
);

   localparam logic [1:0]           LAST_WORD = 2'(WORDS_PER_TRIANGLE - 1);
   localparam logic [INDEX_WIDTH:0] FULL      = (INDEX_WIDTH + 1)'(DEPTH);

   FetcherState            state_q, state_d;
   logic [31:0]            base_q, base_d;
   logic [15:0]            count_q, count_d;
   logic [15:0]            tri_q, tri_d;
   logic [1:0]             word_q, word_d;
   logic                   gap_q, gap_d;
   logic [31:0]            w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
   logic [2:0]             colour_q, colour_d;
   logic [INDEX_WIDTH-1:0] wptr_q, wptr_d;
   logic [INDEX_WIDTH:0]   occ_q, occ_d;
   logic                   mem_en, wr_en, advance, skip, rel_eff;
   TriangleData            record;

   assign record = {colour_q, w2_q, w1_q, w0_q};

`ifdef ILLUSION_BACKFACE_CULL_EN
   logic [15:0]        culled_q, culled_d;
   logic signed [34:0] area;

   TriangleArea u_area (
      .aV0       (record.v0),
      .aV1       (record.v1),
      .aV2       (record.v2),
      .anOutArea (area)
   );

   assign skip             = (area <= 35'sd0);
   assign anOutCulledCount = culled_q;
`else
   assign skip = 1'b0;
`endif

   always_ff @(posedge aClock or negedge aReset) begin
      if (!aReset) begin
         state_q  <= IDLE;
         base_q   <= '0;
         count_q  <= '0;
         tri_q    <= '0;
         word_q   <= '0;
         gap_q    <= 1'b0;
         w0_q     <= '0;
         w1_q     <= '0;
         w2_q     <= '0;
         colour_q <= '0;
         wptr_q   <= '0;
         occ_q    <= '0;
`ifdef ILLUSION_BACKFACE_CULL_EN
         culled_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         count_q  <= count_d;
         tri_q    <= tri_d;
         word_q   <= word_d;
         gap_q    <= gap_d;
         w0_q     <= w0_d;
         w1_q     <= w1_d;
         w2_q     <= w2_d;
         colour_q <= colour_d;
         wptr_q   <= wptr_d;
         occ_q    <= occ_d;
`ifdef ILLUSION_BACKFACE_CULL_EN
         culled_q <= culled_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      count_d  = count_q;
      tri_d    = tri_q;
      word_d   = word_q;
      gap_d    = gap_q;
      w0_d     = w0_q;
      w1_d     = w1_q;
      w2_d     = w2_q;
      colour_d = colour_q;
      wptr_d   = wptr_q;
`ifdef ILLUSION_BACKFACE_CULL_EN
      culled_d = culled_q;
`endif
      mem_en   = 1'b0;
      wr_en    = 1'b0;
      advance  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (aStart) begin
               base_d  = aBaseAddr;
               count_d = aTriangleCount;
               tri_d   = '0;
               word_d  = '0;
               gap_d   = 1'b0;
`ifdef ILLUSION_BACKFACE_CULL_EN
               culled_d = '0;
`endif
               state_d = (aTriangleCount == 16'd0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            // gap_q forces the one idle request cycle between consecutive words
            if (gap_q) begin
               gap_d = 1'b0;
            end else begin
               mem_en = 1'b1;
               if (aMemoryValid) begin
                  case (word_q)
                     2'd0:    w0_d     = aMemoryData;
                     2'd1:    w1_d     = aMemoryData;
                     2'd2:    w2_d     = aMemoryData;
                     default: colour_d = aMemoryData[2:0];
                  endcase
                  word_d = word_q + 2'd1;
                  if (word_q == LAST_WORD) begin
                     gap_d   = 1'b0;
                     state_d = COMMIT;
                  end else begin
                     gap_d = 1'b1;
                  end
               end
            end
         end
         COMMIT: begin
            if (skip) begin
`ifdef ILLUSION_BACKFACE_CULL_EN
               culled_d = culled_q + 16'd1;
`endif
               advance = 1'b1;
            end else if (occ_q < FULL) begin
               wr_en   = 1'b1;
               wptr_d  = (wptr_q == INDEX_WIDTH'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
               advance = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
      endcase
      if (advance) begin
         tri_d   = tri_q + 16'd1;
         word_d  = '0;
         state_d = (tri_q + 16'd1 == count_q) ? DONE : FETCH;
      end
   end

   assign rel_eff = aPrimitiveRelease && (occ_q != '0);

   always_comb begin
      occ_d = occ_q;
      if (wr_en && !rel_eff)
         occ_d = occ_q + 1'b1;
      else if (!wr_en && rel_eff)
         occ_d = occ_q - 1'b1;
   end

   assign anOutMemoryEnable          = mem_en;
   assign anOutMemoryAddr            = mem_en ? base_q + {12'b0, tri_q, 4'b0} + {28'b0, word_q, 2'b0} : '0;
   assign anOutPrimitiveWriteEnable  = wr_en;
   assign anOutPrimitiveWriteAddress = wptr_q;
   assign anOutPrimitiveWriteData    = record;
   assign anOutOccupancy             = occ_q;
   assign anOutBusy                  = (state_q != IDLE);
   assign anOutDone                  = (state_q == DONE);

endmodule

// File: tb/tb_primitive_fetcher.sv
// Randomized self-checking bench for primitive_fetcher against a list-level reference model.
module tb_primitive_fetcher;
   import Types::*;

   localparam int DEPTH = 32;
   localparam int IW    = $clog2(DEPTH);

   logic          aClock = 1'b0;
   logic          aReset = 1'b0;
   logic          aStart = 1'b0;
   logic [31:0]   aBaseAddr = '0;
   logic [15:0]   aTriangleCount = '0;
   logic [31:0]   mem_addr;
   logic [31:0]   aMemoryData = '0;
   logic          mem_en;
   logic          aMemoryValid = 1'b0;
   logic [IW-1:0] wr_addr;
   TriangleData   wr_data;
   logic          wr_en;
   logic          aPrimitiveRelease = 1'b0;
   logic [IW:0]   occ;
   logic          busy, done;
`ifdef ILLUSION_BACKFACE_CULL_EN
   logic [15:0]   culled;
`endif

   primitive_fetcher #(.DEPTH(DEPTH), .INDEX_WIDTH(IW)) dut (
      .aClock                     (aClock),
      .aReset                     (aReset),
      .aStart                     (aStart),
      .aBaseAddr                  (aBaseAddr),
      .aTriangleCount             (aTriangleCount),
      .anOutMemoryAddr            (mem_addr),
      .aMemoryData                (aMemoryData),
      .anOutMemoryEnable          (mem_en),
      .aMemoryValid               (aMemoryValid),
      .anOutPrimitiveWriteAddress (wr_addr),
      .anOutPrimitiveWriteData    (wr_data),
      .anOutPrimitiveWriteEnable  (wr_en),
      .aPrimitiveRelease          (aPrimitiveRelease),
      .anOutOccupancy             (occ),
`ifdef ILLUSION_BACKFACE_CULL_EN
      .anOutCulledCount           (culled),
`endif
      .anOutDone                  (done),
      .anOutBusy                  (busy)
   );

   always #5 aClock = ~aClock;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   typedef struct {
      logic [IW-1:0] slot;
      TriangleData   rec;
   } wr_t;

   wr_t         exp_wr[$];
   logic [31:0] exp_addr[$];
   logic [31:0] mem_ovr [logic [31:0]];
   int          occ_m = 0, wptr_m = 0, culled_m = 0;
   int          wr_cnt = 0, done_cnt = 0, req_cycles = 0, done_mark = 0;
   int          lat_left = 0, max_lat = 0, rel_mode = 0;
   bit          mem_auto = 1'b1, noise = 1'b0;
   logic [31:0] stop_addr = '1;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      if (mem_ovr.exists(addr)) return mem_ovr[addr];
      return (addr * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // Expected reads and cache writes for a whole list, straight from the record/address rules.
   function automatic void build_model(input logic [31:0] base, input int count);
      culled_m = 0;
      for (int t = 0; t < count; t++) begin
         logic [31:0] w [4];
         TriangleData rec;
         bit          cull;
         for (int i = 0; i < 4; i++) begin
            w[i] = mem_word(base + 32'(16 * t + 4 * i));
            exp_addr.push_back(base + 32'(16 * t + 4 * i));
         end
         rec.v0.x   = w[0][15:0];
         rec.v0.y   = w[0][31:16];
         rec.v1.x   = w[1][15:0];
         rec.v1.y   = w[1][31:16];
         rec.v2.x   = w[2][15:0];
         rec.v2.y   = w[2][31:16];
         rec.colour = w[3][2:0];
         cull = 1'b0;
`ifdef ILLUSION_BACKFACE_CULL_EN
         begin
            longint x0, y0, x1, y1, x2, y2, area;
            x0 = longint'(rec.v0.x); y0 = longint'(rec.v0.y);
            x1 = longint'(rec.v1.x); y1 = longint'(rec.v1.y);
            x2 = longint'(rec.v2.x); y2 = longint'(rec.v2.y);
            area = (x1 - x0) * (y2 - y0) - (x2 - x0) * (y1 - y0);
            cull = (area <= 0);
         end
`endif
         if (cull) begin
            culled_m++;
         end else begin
            exp_wr.push_back('{slot: IW'(wptr_m), rec: rec});
            wptr_m = (wptr_m + 1) % DEPTH;
         end
      end
   endfunction

   initial forever begin
      @(negedge aClock);
      if (aReset) begin
         wr_t e;
         check_eq("occupancy", occ, occ_m);
         if (mem_en) req_cycles++;
         if (wr_en) begin
            wr_cnt++;
            check_eq("wr_not_full", occ_m < DEPTH, 1);
            check_eq("wr_expected", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) begin
               e = exp_wr.pop_front();
               check_eq("wr_slot", wr_addr, e.slot);
               check_eq("wr_data", wr_data, e.rec);
            end
         end
         if (done) done_cnt++;
         if (wr_en && !(aPrimitiveRelease && occ_m > 0)) occ_m++;
         else if (!wr_en && aPrimitiveRelease && occ_m > 0) occ_m--;
      end
   end

   // Memory responder, bus noise and release generator; all driven just after the rising edge.
   initial forever begin
      @(posedge aClock);
      #1;
      if (mem_auto) begin
         aMemoryValid = 1'b0;
         if (aReset && mem_en && mem_addr != stop_addr) begin
            if (lat_left == 0) begin
               aMemoryValid = 1'b1;
               aMemoryData  = mem_word(mem_addr);
               check_eq("read_expected", exp_addr.size() > 0, 1);
               if (exp_addr.size() > 0) check_eq("read_addr", mem_addr, exp_addr.pop_front());
               lat_left = int'($urandom_range(max_lat, 0));
            end else begin
               lat_left--;
            end
         end else if (aReset && !mem_en && noise && $urandom_range(3, 0) == 0) begin
            aMemoryValid = 1'b1;
            aMemoryData  = $urandom;
         end
      end
      case (rel_mode)
         1: aPrimitiveRelease = ($urandom_range(3, 0) == 0);
         2: aPrimitiveRelease = wr_en;
         default: ;
      endcase
   end

   task automatic clear_model();
      occ_m    = 0;
      wptr_m   = 0;
      lat_left = 0;
      exp_wr.delete();
      exp_addr.delete();
   endtask

   task automatic do_reset();
      aReset = 1'b0;
      aStart = 1'b0;
      aPrimitiveRelease = 1'b0;
      clear_model();
      repeat (2) @(posedge aClock);
      #3 aReset = 1'b1;
   endtask

   task automatic start_run(input logic [31:0] base, input int count);
      build_model(base, count);
      done_mark = done_cnt;
      @(posedge aClock);
      #2;
      aBaseAddr      = base;
      aTriangleCount = 16'(count);
      aStart         = 1'b1;
      @(posedge aClock);
      #2;
      aStart         = 1'b0;
      aBaseAddr      = $urandom;
      aTriangleCount = 16'($urandom);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cnt == done_mark && n < budget) begin
         @(posedge aClock);
         n++;
      end
      check_eq("done_pulse", done_cnt - done_mark, 1);
      @(negedge aClock);
      check_eq("idle_after_done", busy, 0);
      check_eq("writes_pending", exp_wr.size(), 0);
      check_eq("reads_pending", exp_addr.size(), 0);
`ifdef ILLUSION_BACKFACE_CULL_EN
      check_eq("culled_count", culled, culled_m);
`endif
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, w0, r0;
      #12;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_mem_en", mem_en, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_wr_en", wr_en, 0);
      check_eq("rst_wr_addr", wr_addr, 0);
      check_eq("rst_occ", occ, 0);
      #1 aReset = 1'b1;

      // Single known triangle
      mem_ovr[32'h1000] = 32'h0000_0000;
      mem_ovr[32'h1004] = 32'h0000_000A;
      mem_ovr[32'h1008] = 32'h000A_0000;
      mem_ovr[32'h100C] = 32'h0000_0005;
      w0 = wr_cnt;
      start_run(32'h1000, 1);
      wait_done(100);
      check_eq("single_writes", wr_cnt - w0, 1);

      // Empty list
      r0 = req_cycles;
      start_run(32'h2000, 0);
      wait_done(2);
      check_eq("empty_no_read", req_cycles - r0, 0);

      // Overfill: stall at full until one slot is released
      do_reset();
      w0 = wr_cnt;
      start_run(32'h4000, 33);
      n = 0;
      while (wr_cnt - w0 < 32 && n < 3000) begin
         @(posedge aClock);
         n++;
      end
      repeat (20) @(posedge aClock);
      @(negedge aClock);
      check_eq("full_writes", wr_cnt - w0, 32);
      check_eq("full_occ", occ, 32);
      check_eq("full_busy", busy, 1);
      check_eq("full_no_done", done_cnt - done_mark, 0);
      @(posedge aClock);
      #2 aPrimitiveRelease = 1'b1;
      @(posedge aClock);
      #2 aPrimitiveRelease = 1'b0;
      wait_done(200);
      check_eq("full_total_writes", wr_cnt - w0, 33);

      // Release coincident with every write keeps occupancy flat
      do_reset();
      start_run(32'h8000, 5);
      wait_done(300);
      check_eq("occ_five", occ, 5);
      rel_mode = 2;
      start_run(32'h9000, 3);
      wait_done(300);
      rel_mode = 0;
      aPrimitiveRelease = 1'b0;
      @(negedge aClock);
      check_eq("occ_five_after_rel_wr", occ, 5);

      // Release at empty is ignored
      do_reset();
      @(posedge aClock);
      #2 aPrimitiveRelease = 1'b1;
      @(posedge aClock);
      #2 aPrimitiveRelease = 1'b0;
      @(negedge aClock);
      check_eq("occ_zero_release", occ, 0);

      // Reset while waiting on word 2, then a stray valid
      stop_addr = 32'hA008;
      start_run(32'hA000, 1);
      n = 0;
      while (!(mem_en && mem_addr == stop_addr) && n < 100) begin
         @(posedge aClock);
         n++;
      end
      check_eq("reached_word2", mem_en && mem_addr == stop_addr, 1);
      @(negedge aClock);
      #2 aReset = 1'b0;
      mem_auto = 1'b0;
      aMemoryValid = 1'b0;
      clear_model();
      #1;
      check_eq("abort_mem_en", mem_en, 0);
      check_eq("abort_mem_addr", mem_addr, 0);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_wr_en", wr_en, 0);
      check_eq("abort_occ", occ, 0);
      w0 = wr_cnt;
      @(posedge aClock);
      #3 aReset = 1'b1;
      @(posedge aClock);
      #2;
      aMemoryValid = 1'b1;
      aMemoryData  = 32'h0000_0005;
      @(posedge aClock);
      #2 aMemoryValid = 1'b0;
      repeat (10) @(posedge aClock);
      @(negedge aClock);
      check_eq("abort_no_write", wr_cnt - w0, 0);
      check_eq("abort_idle", busy, 0);
      stop_addr = '1;
      mem_auto  = 1'b1;

`ifdef ILLUSION_BACKFACE_CULL_EN
      // Clockwise triangle is culled
      mem_ovr[32'hC000] = 32'h0000_0000;
      mem_ovr[32'hC004] = 32'h000A_0000;
      mem_ovr[32'hC008] = 32'h0000_000A;
      mem_ovr[32'hC00C] = 32'h0000_0001;
      w0 = wr_cnt;
      start_run(32'hC000, 1);
      wait_done(100);
      check_eq("cull_no_write", wr_cnt - w0, 0);
      check_eq("cull_count_one", culled, 1);
`endif

      // Randomized lists with latency, noise and random releases
      do_reset();
      noise    = 1'b1;
      rel_mode = 1;
      max_lat  = 2;
      start_run(32'hFFFF_FFF0, 3);
      wait_done(400);
      for (int k = 0; k < 6; k++) begin
         max_lat = int'($urandom_range(3, 0));
         start_run($urandom, int'($urandom_range(40, 1)));
         wait_done(2400);
      end
      rel_mode = 0;
      noise    = 1'b0;
      aPrimitiveRelease = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
